// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller for the 2-wide pipeline (slot 1 older, slot 2 younger).
// Picks the oldest mispredicting branch, redirects fetch via a valid/ready handshake,
// then holds a pipeline flush for FLUSH_CYCLES cycles. Counts detected mispredicts.
module branch_redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_in1,
  input  logic              branch_in2,
  input  logic              taken1,
  input  logic              taken2,
  input  logic              pred_taken1,
  input  logic              pred_taken2,
  input  logic [XLEN-1:0]   pc1,
  input  logic [XLEN-1:0]   pc2,
  input  logic [XLEN-1:0]   target1,
  input  logic [XLEN-1:0]   target2,
  input  logic              fetch_ready,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush_slot2,
  output logic              flush_pipe,
  output logic              stall_issue,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FcW-1:0]  FcLoad = FcW'(FLUSH_CYCLES);
  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  typedef enum logic [1:0] {
    StIdle,
    StRedirect,
    StFlush
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [FcW-1:0]   fc_q, fc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mis1, mis2;
  logic [XLEN-1:0]  cpc1, cpc2;
  logic             slot2_kill;

  assign mis1 = branch_in1 & (taken1 != pred_taken1);
  assign mis2 = branch_in2 & (taken2 != pred_taken2);
  // Fall-through PC wraps modulo 2^XLEN.
  assign cpc1 = taken1 ? target1 : (pc1 + PcStep);
  assign cpc2 = taken2 ? target2 : (pc2 + PcStep);

  // Next-state: capture the oldest mispredict in idle, handshake, then count down the flush.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fc_d       = fc_q;
    cnt_d      = cnt_q;
    slot2_kill = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mis1) begin
          // Slot 2 is younger than a mispredicting slot 1: it is wrong-path, never counted.
          slot2_kill = 1'b1;
          pc_d       = cpc1;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = StRedirect;
        end else if (mis2) begin
          pc_d    = cpc2;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        if (fetch_ready) begin
          fc_d    = FcLoad;
          state_d = StFlush;
        end
      end
      StFlush: begin
        fc_d = fc_q - FcW'(1);
        if (fc_q <= FcW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, captured PC, flush countdown and mispredict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      fc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fc_q    <= fc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign redirect_valid = (state_q == StRedirect);
  // PC is only presented while valid so that idle outputs read as zero.
  assign redirect_pc    = redirect_valid ? pc_q : '0;
  assign flush_pipe     = (state_q != StIdle);
  assign stall_issue    = (state_q != StIdle);
  // Combinational path must drop during reset without waiting for the state flops.
  assign flush_slot2    = slot2_kill & rst_n;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; a second instance with a 2-bit counter
// shares the stimulus to exercise counter wrap.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_in1, branch_in2, taken1, taken2, pred_taken1, pred_taken2;
  logic [31:0] pc1, pc2, target1, target2;
  logic        fetch_ready;

  logic        redirect_valid, flush_slot2, flush_pipe, stall_issue;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_cnt;

  logic        redirect_valid_b, flush_slot2_b, flush_pipe_b, stall_issue_b;
  logic [31:0] redirect_pc_b;
  logic [1:0]  mispredict_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_in1     (branch_in1),
    .branch_in2     (branch_in2),
    .taken1         (taken1),
    .taken2         (taken2),
    .pred_taken1    (pred_taken1),
    .pred_taken2    (pred_taken2),
    .pc1            (pc1),
    .pc2            (pc2),
    .target1        (target1),
    .target2        (target2),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_slot2    (flush_slot2),
    .flush_pipe     (flush_pipe),
    .stall_issue    (stall_issue),
    .mispredict_cnt (mispredict_cnt)
  );

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut_w2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_in1     (branch_in1),
    .branch_in2     (branch_in2),
    .taken1         (taken1),
    .taken2         (taken2),
    .pred_taken1    (pred_taken1),
    .pred_taken2    (pred_taken2),
    .pc1            (pc1),
    .pc2            (pc2),
    .target1        (target1),
    .target2        (target2),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid_b),
    .redirect_pc    (redirect_pc_b),
    .flush_slot2    (flush_slot2_b),
    .flush_pipe     (flush_pipe_b),
    .stall_issue    (stall_issue_b),
    .mispredict_cnt (mispredict_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    branch_in1 = 1'b0; branch_in2 = 1'b0;
    taken1 = 1'b0; taken2 = 1'b0; pred_taken1 = 1'b0; pred_taken2 = 1'b0;
    pc1 = '0; pc2 = '0; target1 = '0; target2 = '0;
    fetch_ready = 1'b1;
  endtask

  // Wait (bounded) for the controller to go quiet with fetch accepting.
  task automatic drain();
    clr();
    for (int i = 0; i < 10; i++) begin
      if (!flush_pipe && !redirect_valid) break;
      step();
    end
    chk("drain_idle", {30'd0, flush_pipe, redirect_valid}, 32'd0);
  endtask

  // Launch a slot 1 mispredict and step into the redirect state.
  task automatic mis_slot1(input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
    clr();
    branch_in1 = 1'b1; taken1 = tk; pred_taken1 = ~tk; pc1 = pc; target1 = tgt;
    step();
    clr();
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_pc",    redirect_pc, 32'd0);
    chk("rst_flush", {30'd0, flush_pipe, stall_issue}, 32'd0);
    chk("rst_cnt",   {16'd0, mispredict_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Correct predictions for 10 cycles: nothing happens.
    for (int i = 0; i < 10; i++) begin
      branch_in1 = 1'b1; branch_in2 = i[0];
      taken1 = i[1]; pred_taken1 = i[1];
      taken2 = i[2]; pred_taken2 = i[2];
      pc1 = 32'h1000 + 32'(i); target1 = 32'h2000;
      #1;
      chk("ok_slot2", {31'd0, flush_slot2}, 32'd0);
      step();
      chk("ok_quiet", {29'd0, redirect_valid, flush_pipe, stall_issue}, 32'd0);
    end
    chk("ok_cnt", {16'd0, mispredict_cnt}, 32'd0);

    // Slot 1 taken mispredict; slot 2 also mispredicts but must be ignored.
    clr();
    branch_in1 = 1'b1; taken1 = 1'b1; pred_taken1 = 1'b0; target1 = 32'h100; pc1 = 32'h50;
    branch_in2 = 1'b1; taken2 = 1'b1; pred_taken2 = 1'b0; target2 = 32'h777;
    #1;
    chk("t1_slot2_kill", {31'd0, flush_slot2}, 32'd1);
    chk("t1_not_yet",    {31'd0, redirect_valid}, 32'd0);
    step();
    clr();
    chk("t1_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t1_pc",    redirect_pc, 32'h100);
    chk("t1_flush0", {30'd0, flush_pipe, stall_issue}, 32'd3);
    chk("t1_cnt",   {16'd0, mispredict_cnt}, 32'd1);
    chk("t1_slot2_off", {31'd0, flush_slot2}, 32'd0);
    step();
    chk("t1_flush1", {30'd0, flush_pipe, redirect_valid}, 32'd2);
    step();
    chk("t1_flush2", {31'd0, flush_pipe}, 32'd1);
    step();
    chk("t1_flush_end", {30'd0, flush_pipe, stall_issue}, 32'd0);
    chk("t1_cnt_hold", {16'd0, mispredict_cnt}, 32'd1);

    // Slot 2 not-taken mispredict behind a correct slot 1.
    clr();
    branch_in1 = 1'b1; taken1 = 1'b1; pred_taken1 = 1'b1; target1 = 32'h900;
    branch_in2 = 1'b1; pc2 = 32'h204; taken2 = 1'b0; pred_taken2 = 1'b1;
    #1;
    chk("t3_slot2", {31'd0, flush_slot2}, 32'd0);
    step();
    clr();
    chk("t3_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t3_pc",    redirect_pc, 32'h208);
    chk("t3_cnt",   {16'd0, mispredict_cnt}, 32'd2);
    drain();

    // Backpressure: fetch not ready for 3 cycles while wrong-path mispredicts arrive.
    clr();
    branch_in1 = 1'b1; taken1 = 1'b0; pred_taken1 = 1'b1; pc1 = 32'h300;
    fetch_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      branch_in1 = 1'b1; taken1 = 1'b1; pred_taken1 = 1'b0; target1 = 32'h999;
      branch_in2 = 1'b1; taken2 = 1'b1; pred_taken2 = 1'b0; target2 = 32'h888;
      fetch_ready = 1'b0;
      #1;
      chk("t4_slot2", {31'd0, flush_slot2}, 32'd0);
      chk("t4_valid", {31'd0, redirect_valid}, 32'd1);
      chk("t4_pc",    redirect_pc, 32'h304);
      chk("t4_cnt",   {16'd0, mispredict_cnt}, 32'd3);
      step();
    end
    fetch_ready = 1'b1;
    step();
    chk("t4_hs_valid", {31'd0, redirect_valid}, 32'd0);
    chk("t4_hs_flush", {31'd0, flush_pipe}, 32'd1);
    step();
    chk("t4_fl_cnt", {16'd0, mispredict_cnt}, 32'd3);
    chk("t4_fl_slot2", {31'd0, flush_slot2}, 32'd0);
    clr();
    step();
    chk("t4_idle", {31'd0, flush_pipe}, 32'd0);
    chk("t4_cnt_end", {16'd0, mispredict_cnt}, 32'd3);

    // Asynchronous reset in the middle of the flush.
    mis_slot1(1'b1, 32'h40, 32'h400);
    chk("t5_cnt", {16'd0, mispredict_cnt}, 32'd4);
    step();
    chk("t5_in_flush", {31'd0, flush_pipe}, 32'd1);
    #2;
    branch_in1 = 1'b1; taken1 = 1'b1; pred_taken1 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, redirect_valid}, 32'd0);
    chk("t5_rst_pc",    redirect_pc, 32'd0);
    chk("t5_rst_flush", {30'd0, flush_pipe, stall_issue}, 32'd0);
    chk("t5_rst_slot2", {31'd0, flush_slot2}, 32'd0);
    chk("t5_rst_cnt",   {16'd0, mispredict_cnt}, 32'd0);
    clr();
    step();
    rst_n = 1'b1;
    step();
    chk("t5_post_idle", {29'd0, redirect_valid, flush_pipe, stall_issue}, 32'd0);
    chk("t5_post_cnt",  {16'd0, mispredict_cnt}, 32'd0);

    // Narrow counter wrap and fall-through PC wrap.
    mis_slot1(1'b1, 32'h0, 32'hA0);
    chk("t6_cnt1", {30'd0, mispredict_cnt_b}, 32'd1);
    drain();
    mis_slot1(1'b0, 32'h10, 32'h0);
    chk("t6_pc_nt", redirect_pc, 32'h14);
    chk("t6_cnt2", {30'd0, mispredict_cnt_b}, 32'd2);
    drain();
    mis_slot1(1'b1, 32'h0, 32'hC0);
    chk("t6_cnt3", {30'd0, mispredict_cnt_b}, 32'd3);
    drain();
    mis_slot1(1'b0, 32'hFFFF_FFFC, 32'h1234);
    chk("t6_cnt_wrap", {30'd0, mispredict_cnt_b}, 32'd0);
    chk("t6_valid",    {31'd0, redirect_valid}, 32'd1);
    chk("t6_pc_wrap",  redirect_pc, 32'h0);
    chk("t6_cnt_wide", {16'd0, mispredict_cnt}, 32'd4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
